// File: rtl/bp_l15_store_buffer_if.sv
// L1.5 request/return channel shared by the store buffer and the load-miss transducer.
// The master side issues requests and consumes returns.
interface bp_l15_store_buffer_if #(
    parameter int paddr_width_p = 40
);
    logic                     transducer_l15_val;
    logic [4:0]               transducer_l15_rqtype;
    logic [2:0]               transducer_l15_size;
    logic [paddr_width_p-1:0] transducer_l15_address;
    logic [63:0]              transducer_l15_data;
    logic                     l15_transducer_ack;
    logic                     l15_transducer_val;
    logic [3:0]               l15_transducer_returntype;
    logic                     transducer_l15_req_ack;

    modport master (
        output transducer_l15_val,
        output transducer_l15_rqtype,
        output transducer_l15_size,
        output transducer_l15_address,
        output transducer_l15_data,
        output transducer_l15_req_ack,
        input  l15_transducer_ack,
        input  l15_transducer_val,
        input  l15_transducer_returntype
    );

    modport slave (
        input  transducer_l15_val,
        input  transducer_l15_rqtype,
        input  transducer_l15_size,
        input  transducer_l15_address,
        input  transducer_l15_data,
        input  transducer_l15_req_ack,
        output l15_transducer_ack,
        output l15_transducer_val,
        output l15_transducer_returntype
    );
endinterface

// File: rtl/bp_l15_store_buffer.sv
// Store buffer between the BlackParrot dcache and the OpenPiton L1.5: FIFOs dcache stores
// and issues them one at a time as STORE_RQ, retiring each entry on its ST_ACK.
module bp_l15_store_buffer #(
    parameter int els_p         = 4,
    parameter int paddr_width_p = 40
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     store_v_i,
    output logic                     store_ready_o,
    input  logic [paddr_width_p-1:0] store_addr_i,
    input  logic [63:0]              store_data_i,
    input  logic [1:0]               store_size_i,
    output logic                     empty_o,
    input  logic                     issue_en_i,
    bp_l15_store_buffer_if.master    l15
);
    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = ptr_w + 1;
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);
    localparam logic [4:0] store_rq = 5'b00001;
    localparam logic [3:0] st_ack   = 4'b0100;

    typedef struct packed {
        logic [paddr_width_p-1:0] addr;
        logic [63:0]              data;
        logic [1:0]               size;
    } entry_t;

    typedef enum logic [1:0] {e_idle, e_send, e_wait} state_e;

    entry_t           mem_q [els_p];
    logic [ptr_w-1:0] head_q, head_d, tail_q, tail_d;
    logic [cnt_w-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic             push, pop, st_ack_v;
    entry_t           head;
    logic [63:0]      rep_data, fmt_data;

    assign store_ready_o = rst_n & (count_q != full_cnt);
    assign push          = store_v_i & store_ready_o;
    assign head          = mem_q[head_q];
    assign st_ack_v      = l15.l15_transducer_val & (l15.l15_transducer_returntype == st_ack);
    assign empty_o       = (count_q == '0) && (state_q == e_idle);

    // Replicate the right-justified store bytes across the doubleword, then go big-endian.
    always_comb begin
        rep_data = head.data;
        fmt_data = '0;
        case (head.size)
            2'd0:    rep_data = {8{head.data[7:0]}};
            2'd1:    rep_data = {4{head.data[15:0]}};
            2'd2:    rep_data = {2{head.data[31:0]}};
            default: rep_data = head.data;
        endcase
        for (int i = 0; i < 8; i++) begin
            fmt_data[8*i +: 8] = rep_data[8*(7-i) +: 8];
        end
    end

    // NOTE: every output and next-state value gets a default before the case so no latch is inferred.
    always_comb begin
        state_d                    = state_q;
        pop                        = 1'b0;
        l15.transducer_l15_val     = 1'b0;
        l15.transducer_l15_rqtype  = '0;
        l15.transducer_l15_size    = '0;
        l15.transducer_l15_address = '0;
        l15.transducer_l15_data    = '0;
        l15.transducer_l15_req_ack = 1'b0;
        case (state_q)
            e_idle: begin
                if ((count_q != '0) && issue_en_i) state_d = e_send;
            end
            e_send: begin
                l15.transducer_l15_val     = 1'b1;
                l15.transducer_l15_rqtype  = store_rq;
                l15.transducer_l15_size    = {1'b0, head.size};
                l15.transducer_l15_address = head.addr;
                l15.transducer_l15_data    = fmt_data;
                if (l15.l15_transducer_ack) state_d = e_wait;
            end
            e_wait: begin
                // Returns other than ST_ACK belong to the load path and are left alone.
                l15.transducer_l15_req_ack = st_ack_v;
                if (st_ack_v) begin
                    pop     = 1'b1;
                    state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + ptr_w'(1);
        if (pop)  head_d = head_q + ptr_w'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + cnt_w'(1);
            2'b01:   count_d = count_q - cnt_w'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= e_idle;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[tail_q] <= '{addr: store_addr_i, data: store_data_i, size: store_size_i};
        end
    end
endmodule

// File: tb/tb_bp_l15_store_buffer.sv
// Bench for bp_l15_store_buffer: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_bp_l15_store_buffer;
    localparam logic [4:0] STORE_RQ = 5'b00001;
    localparam logic [3:0] ST_ACK   = 4'b0100;
    localparam logic [3:0] LOAD_RET = 4'b0000;
    localparam int PH_IDLE = 0, PH_SEND = 1, PH_WAIT = 2;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        store_v_i = 1'b0;
    logic        store_ready_o;
    logic [39:0] store_addr_i = '0;
    logic [63:0] store_data_i = '0;
    logic [1:0]  store_size_i = '0;
    logic        empty_o;
    logic        issue_en_i = 1'b1;

    int total = 0;
    int bad   = 0;

    bp_l15_store_buffer_if #(.paddr_width_p(40)) l15 ();

    bp_l15_store_buffer #(.els_p(4), .paddr_width_p(40)) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .store_v_i     (store_v_i),
        .store_ready_o (store_ready_o),
        .store_addr_i  (store_addr_i),
        .store_data_i  (store_data_i),
        .store_size_i  (store_size_i),
        .empty_o       (empty_o),
        .issue_en_i    (issue_en_i),
        .l15           (l15)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [39:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
    } st_t;

    st_t m_q[$];
    int  m_phase = PH_IDLE;

    function automatic logic [63:0] fmt(input logic [63:0] d, input logic [1:0] sz);
        int nb;
        logic [63:0] low, rep;
        nb  = 1 << sz;
        low = (nb == 8) ? d : (d & ((64'd1 << (nb * 8)) - 64'd1));
        rep = '0;
        for (int k = 0; k < 8 / nb; k++) rep = rep | (low << (k * nb * 8));
        return {<<8{rep}};
    endfunction

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_phase = PH_IDLE;
        end else begin
            bit do_push, do_pop;
            do_push = store_v_i && (m_q.size() < 4);
            do_pop  = (m_phase == PH_WAIT) && l15.l15_transducer_val
                      && (l15.l15_transducer_returntype == ST_ACK);
            if (m_phase == PH_IDLE && m_q.size() != 0 && issue_en_i) m_phase = PH_SEND;
            else if (m_phase == PH_SEND && l15.l15_transducer_ack)  m_phase = PH_WAIT;
            else if (do_pop)                                         m_phase = PH_IDLE;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back('{addr: store_addr_i, data: store_data_i, size: store_size_i});
        end
    end

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clk_i) begin
        bit ev, ea;
        ev = (m_phase == PH_SEND);
        ea = (m_phase == PH_WAIT) && l15.l15_transducer_val
             && (l15.l15_transducer_returntype == ST_ACK);
        check("m_val",    l15.transducer_l15_val, ev);
        check("m_rqtype", l15.transducer_l15_rqtype, ev ? STORE_RQ : 5'd0);
        check("m_size",   l15.transducer_l15_size, ev ? {1'b0, m_q[0].size} : 3'd0);
        check("m_addr",   l15.transducer_l15_address, ev ? m_q[0].addr : 40'd0);
        check("m_data",   l15.transducer_l15_data, ev ? fmt(m_q[0].data, m_q[0].size) : 64'd0);
        check("m_reqack", l15.transducer_l15_req_ack, ea);
        check("m_ready",  store_ready_o, rst_n && (m_q.size() < 4));
        check("m_empty",  empty_o, (m_q.size() == 0) && (m_phase == PH_IDLE));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_store(input logic [39:0] a, input logic [63:0] d, input logic [1:0] s);
        store_v_i = 1'b1; store_addr_i = a; store_data_i = d; store_size_i = s;
        tick();
        store_v_i = 1'b0;
    endtask

    task automatic wait_val(input int budget);
        int n = 0;
        while (l15.transducer_l15_val !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("val_wait", l15.transducer_l15_val, 1'b1);
    endtask

    task automatic serve_one(input logic [39:0] a, input logic [63:0] d, input logic [2:0] s);
        wait_val(20);
        check("req_rqtype", l15.transducer_l15_rqtype, STORE_RQ);
        check("req_addr",   l15.transducer_l15_address, a);
        check("req_data",   l15.transducer_l15_data, d);
        check("req_size",   l15.transducer_l15_size, s);
        l15.l15_transducer_ack = 1'b1;
        tick();
        l15.l15_transducer_ack = 1'b0;
        check("val_after_ack", l15.transducer_l15_val, 1'b0);
        l15.l15_transducer_val = 1'b1;
        l15.l15_transducer_returntype = ST_ACK;
        #1 check("st_ack_consumed", l15.transducer_l15_req_ack, 1'b1);
        tick();
        l15.l15_transducer_val = 1'b0;
        check("req_ack_pulse", l15.transducer_l15_req_ack, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        l15.l15_transducer_ack = 1'b0;
        l15.l15_transducer_val = 1'b0;
        l15.l15_transducer_returntype = LOAD_RET;

        // Reset state
        repeat (3) tick();
        check("rst_ready", store_ready_o, 1'b0);
        check("rst_empty", empty_o, 1'b1);
        check("rst_val",   l15.transducer_l15_val, 1'b0);
        rst_n = 1'b1;
        #1;
        check("first_ready", store_ready_o, 1'b1);
        tick();

        // Single 8B store: val exactly two edges after enqueue
        push_store(40'h80_0000_1000, 64'h1122334455667788, 2'd3);
        check("no_bypass", l15.transducer_l15_val, 1'b0);
        tick();
        check("val_at_n2", l15.transducer_l15_val, 1'b1);
        serve_one(40'h80_0000_1000, 64'h8877665544332211, 3'd3);
        check("empty_after_8b", empty_o, 1'b1);

        // Narrow sizes: replication and byte swap
        push_store(40'h80_0000_2007, 64'h00000000000000AB, 2'd0);
        serve_one(40'h80_0000_2007, 64'hABABABABABABABAB, 3'd0);
        push_store(40'h80_0000_2102, 64'h000000000000BEEF, 2'd1);
        serve_one(40'h80_0000_2102, 64'hEFBEEFBEEFBEEFBE, 3'd1);
        push_store(40'h80_0000_2204, 64'h00000000DEADBEEF, 2'd2);
        serve_one(40'h80_0000_2204, 64'hEFBEADDEEFBEADDE, 3'd2);

        // Fill and backpressure: 4 accepted, 5th stalls until the first ST_ACK
        for (int i = 0; i < 4; i++) push_store(40'h80_0000_3000 + 40'(i * 8), 64'h1111111111111111 * 64'(i + 1), 2'd3);
        check("full_ready", store_ready_o, 1'b0);
        store_v_i = 1'b1; store_addr_i = 40'h80_0000_3020; store_data_i = 64'h5555555555555555; store_size_i = 2'd3;
        tick();
        tick();
        check("stall_ready", store_ready_o, 1'b0);
        serve_one(40'h80_0000_3000, 64'h1111111111111111, 3'd3);
        check("ready_after_pop", store_ready_o, 1'b1);
        tick();
        store_v_i = 1'b0;
        check("refull_ready", store_ready_o, 1'b0);
        for (int i = 1; i < 5; i++) serve_one(40'h80_0000_3000 + 40'(i * 8), 64'h1111111111111111 * 64'(i + 1), 3'd3);
        check("empty_after_fill", empty_o, 1'b1);

        // ack and ST_ACK together in e_send, then a foreign return in e_wait
        push_store(40'h80_0000_4000, 64'h0123456789ABCDEF, 2'd3);
        wait_val(10);
        l15.l15_transducer_ack = 1'b1;
        l15.l15_transducer_val = 1'b1;
        l15.l15_transducer_returntype = ST_ACK;
        #1 check("no_ack_in_send", l15.transducer_l15_req_ack, 1'b0);
        tick();
        l15.l15_transducer_ack = 1'b0;
        l15.l15_transducer_returntype = LOAD_RET;
        #1 check("foreign_ignored", l15.transducer_l15_req_ack, 1'b0);
        tick();
        tick();
        check("still_waiting", empty_o, 1'b0);
        check("no_reissue", l15.transducer_l15_val, 1'b0);
        l15.l15_transducer_returntype = ST_ACK;
        #1 check("st_ack_after_foreign", l15.transducer_l15_req_ack, 1'b1);
        tick();
        l15.l15_transducer_val = 1'b0;
        check("empty_after_foreign", empty_o, 1'b1);

        // Issue gating
        issue_en_i = 1'b0;
        push_store(40'h80_0000_5000, 64'h00000000000000C3, 2'd0);
        push_store(40'h80_0000_5001, 64'h00000000000000C4, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("gated_val", l15.transducer_l15_val, 1'b0);
        end
        issue_en_i = 1'b1;
        tick();
        check("val_after_enable", l15.transducer_l15_val, 1'b1);
        issue_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("val_held", l15.transducer_l15_val, 1'b1);
        end
        serve_one(40'h80_0000_5000, 64'hC3C3C3C3C3C3C3C3, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gated_second", l15.transducer_l15_val, 1'b0);
        end
        issue_en_i = 1'b1;
        serve_one(40'h80_0000_5001, 64'hC4C4C4C4C4C4C4C4, 3'd0);

        // Async reset mid-cycle in e_wait with entries buffered
        for (int i = 0; i < 4; i++) push_store(40'h80_0000_6000 + 40'(i), 64'h00000000000000E0 + 64'(i), 2'd0);
        wait_val(10);
        l15.l15_transducer_ack = 1'b1;
        tick();
        l15.l15_transducer_ack = 1'b0;
        l15.l15_transducer_val = 1'b1;
        l15.l15_transducer_returntype = ST_ACK;
        #1 check("pre_rst_reqack", l15.transducer_l15_req_ack, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_reqack_drop", l15.transducer_l15_req_ack, 1'b0);
        check("rst_ready_drop",  store_ready_o, 1'b0);
        check("rst_val_drop",    l15.transducer_l15_val, 1'b0);
        check("rst_empty_now",   empty_o, 1'b1);
        l15.l15_transducer_val = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_empty", empty_o, 1'b1);
        check("post_rst_ready", store_ready_o, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_no_req", l15.transducer_l15_val, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_l15_store_buffer.md
# bp_l15_store_buffer

Store-side request stage between the BlackParrot dcache and the OpenPiton L1.5. Buffers dcache store requests in a small FIFO and issues them to the L1.5 one at a time as `STORE_RQ` transactions. Each entry is retired only when its `ST_ACK` return arrives. It runs beside the load-miss transducer and shares the same L1.5 request/return channel under an external issue-enable from that transducer.

## Interface
Parameters:
- `els_p`, 4 — store FIFO depth (power of 2, ≥2)
- `paddr_width_p`, 40 — physical address width

Ports:
- `clk_i`  in  1  — clock. One clock domain.
- `rst_n`  in  1  — reset. Asynchronous, active-low.
- `store_v_i`  in  1  — store request valid
- `store_ready_o`  out  1  — FIFO can accept; 0 while full or in reset
- `store_addr_i`  in  40  — store physical address, naturally aligned to size
- `store_data_i`  in  64  — store data, little-endian, right-justified
- `store_size_i`  in  2  — 0=1B, 1=2B, 2=4B, 3=8B
- `empty_o`  out  1  — no buffered or in-flight store (fence/drain indicator)
- `issue_en_i`  in  1  — load path idle; a new store may start
- `transducer_l15_val`  out  1  — request valid
- `transducer_l15_rqtype`  out  5  — `` `STORE_RQ `` when val, else 0
- `transducer_l15_size`  out  3  — `{1'b0, size}` (`` `PCX_SZ_1B ``..`` `PCX_SZ_8B ``)
- `transducer_l15_address`  out  40  — head entry address
- `transducer_l15_data`  out  64  — formatted store data
- `l15_transducer_ack`  in  1  — request accepted
- `l15_transducer_val`  in  1  — return valid
- `l15_transducer_returntype`  in  4  — return type
- `transducer_l15_req_ack`  out  1  — return consumed by this block

## Operation
- **FIFO**
  - Storage: `els_p` entries × {addr, data, size}, head/tail pointers, count of width clog2(`els_p`)+1.
  - Enqueue when `store_v_i & store_ready_o`.
  - `store_ready_o = rst_n & (count != els_p)`. When full, there is no enqueue even if a dequeue happens the same cycle.
  - Dequeue only on the `ST_ACK` consume. Pointers wrap modulo `els_p`.
- **Data formatting (combinational from head)**
  - Replicate the low bytes to fill 64 bits: 1B ×8, 2B ×4, 4B ×2, 8B ×1.
  - Then byte-swap to big-endian: out byte i = replicated byte 7−i.
- **Address**: passed unchanged. No alignment check.
- **FSM** (`e_idle`, `e_send`, `e_wait`):
  - `e_idle`: if count≠0 and `issue_en_i`, go to `e_send`. `issue_en_i` is sampled only here.
  - `e_send`: `transducer_l15_val`=1, with rqtype/size/address/data from head. Hold every field stable until `l15_transducer_ack`. On ack, go to `e_wait`. Ignore `issue_en_i` in this state.
  - `e_wait`: `transducer_l15_req_ack = l15_transducer_val & (returntype == `ST_ACK`)`. On that condition, pop the head and go to `e_idle`. Ignore all other return types; req_ack stays 0 for them, since they belong to the load path.
  - `req_ack` is 0 in all other states.
- At most one store in flight. Stores retire in enqueue order.
- `empty_o = (count == 0) & (state == e_idle)`.
- **Simultaneous enqueue + ST_ACK pop**: count unchanged, both pointers advance.

## Timing
- **Reset (`rst_n` low, asynchronous)**:
  - State `e_idle`, count/pointers 0.
  - Outputs: `transducer_l15_val`=0, rqtype/size/address/data=0, `req_ack`=0, `store_ready_o`=0, `empty_o`=1.
  - Storage contents are don't-care.
- **Reset asserted mid-transaction**: the in-flight store and all buffered stores are discarded. No ST_ACK is expected after release.
- **First `store_ready_o`**: 1 in the first cycle after `rst_n` rises.
- **Enqueue to request**: an enqueue at cycle N (FIFO was empty, `issue_en_i`=1) gives val=1 at cycle N+2 (N+1: state register → `e_send`). There is no bypass.
- **Request to ack**: ack at cycle M moves to `e_wait` at M+1. `val` is 0 from M+1.
- **ST_ACK to next request**: ST_ACK at cycle K is consumed combinationally at K (`req_ack`=1 at K). Pop and `e_idle` take effect at K+1. The next val is at K+2 if count≠0 and `issue_en_i`=1.
- **ack and ST_ACK in the same cycle while in `e_send`**: the ST_ACK is not consumed; only the ack is taken.

## Test plan
- **Single 8B store**: store at 0x80_0000_1000 with data 0x1122334455667788, size 3.
  - Required: val at N+2 with rqtype `STORE_RQ`, size 3, address 0x8000001000, data 0x8877665544332211.
  - Ack, then ST_ACK → `req_ack` pulses 1 cycle, `empty_o` returns to 1.
- **1B replication**: data 0xAB, size 0, address 0x...07 → data 0xABABABABABABABAB, size 0, address unchanged.
- **Fill and backpressure**:
  - 5 back-to-back stores with L1.5 ack withheld → `store_ready_o`=0 after the 4th enqueue; the 5th is stalled until the first ST_ACK pops.
  - All 5 are issued in order with addresses intact.
- **Foreign return**: `LOAD_RET` asserted during `e_wait` → `req_ack`=0, state stays `e_wait`. A following `ST_ACK` is consumed.
- **Issue gating**: entries buffered with `issue_en_i`=0 → no val.
  - Raise `issue_en_i` → val 1 cycle later.
  - Drop `issue_en_i` while in `e_send` → val held until ack.
- **Async reset**: assert `rst_n`=0 mid-cycle in `e_wait` with 3 entries buffered → val/`req_ack`/ready drop immediately. After release: `empty_o`=1, `store_ready_o`=1, no request issued.
